// File: rtl/dmem_responder.sv
// -----------------------------------------------------------------------------
// dmem_responder
//
// Slave end of the core's mem_in/mem_out data port. Models a word-addressed
// 32-bit SRAM with WAIT_CYCLES wait states. It holds one active request and
// a one-entry pending buffer, and returns one mem_ready pulse per accepted
// request.
//
// Handshake: mem_valid is a one-cycle strobe. The request fields are sampled
// on the same rising edge and need not be held afterwards. There is no ready
// back-pressure toward the requester. A request that arrives while both the
// active slot and the pending buffer are occupied (WAIT state, pending full)
// is dropped, and the sticky overflow flag is set. Each accepted request gets
// exactly one cycle with mem_ready=1. mem_rdata and mem_error are
// meaningful only in that cycle and read 0 at all other times.
//
// Parameters:
//   DEPTH_LOG2  - log2 of the number of 32-bit words
//   WAIT_CYCLES - extra cycles between capture and response (0..15)
//
// Optional feature macro: DMEM_RANGE_CHECK_EN
//   Defined: any set bit in mem_addr[31:DEPTH_LOG2+2] faults the access. No
//            array update happens, and the response carries mem_error=1 and
//            mem_rdata=0.
//   Undefined: the upper address bits are ignored, so addresses alias.
//
// Ports:
//   rst        in   asynchronous active-low reset
//   clk        in   rising-edge clock
//   mem_valid  in   request strobe
//   mem_instr  in   instruction-fetch flag (accepted, unused)
//   mem_addr   in   byte address, word index = mem_addr[DEPTH_LOG2+1:2]
//   mem_wdata  in   lane-aligned store data
//   mem_wstrb  in   byte enables, 0 = load
//   mem_ready  out  one-cycle response pulse
//   mem_rdata  out  load data (valid with mem_ready)
//   mem_error  out  access fault (valid with mem_ready)
//   overflow   out  sticky dropped-request flag
//   dbg_state  out  current FSM state (IDLE=0, WAIT=1, RESP=2)
// -----------------------------------------------------------------------------
module dmem_responder #(
    parameter int DEPTH_LOG2  = 12,
    parameter int WAIT_CYCLES = 1
) (
    input  logic        rst,
    input  logic        clk,
    input  logic        mem_valid,
    input  logic        mem_instr,
    input  logic [31:0] mem_addr,
    input  logic [31:0] mem_wdata,
    input  logic [3:0]  mem_wstrb,
    output logic        mem_ready,
    output logic [31:0] mem_rdata,
    output logic        mem_error,
    output logic        overflow,
    output logic [1:0]  dbg_state
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_RESP = 2'd2
    } state_t;

    localparam logic [3:0] CNT_INIT = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

    state_t                state_q, state_d;
    logic [3:0]            cnt_q, cnt_d;
    logic                  ovf_q, ovf_d;
    logic [31:0]           rdata_q;
    logic                  error_q;

    // Active request: the one currently counting down or being answered.
    logic [DEPTH_LOG2-1:0] act_idx_q, act_idx_d;
    logic [31:0]           act_wdata_q, act_wdata_d;
    logic [3:0]            act_wstrb_q, act_wstrb_d;
    logic                  act_err_q, act_err_d;

    // One-entry pending buffer.
    logic                  pend_vld_q, pend_vld_d;
    logic [DEPTH_LOG2-1:0] pend_idx_q, pend_idx_d;
    logic [31:0]           pend_wdata_q, pend_wdata_d;
    logic [3:0]            pend_wstrb_q, pend_wstrb_d;
    logic                  pend_err_q, pend_err_d;

    logic                  start;
    logic [DEPTH_LOG2-1:0] in_idx;
    logic                  in_err;
    logic                  unused_bits;

    logic [31:0]           mem [0:(1<<DEPTH_LOG2)-1];

    assign in_idx = mem_addr[DEPTH_LOG2+1:2];

`ifdef DMEM_RANGE_CHECK_EN
    assign in_err = |mem_addr[31:DEPTH_LOG2+2];
`else
    assign in_err = 1'b0;
`endif

    assign unused_bits = ^{mem_instr, mem_addr[1:0], mem_addr[31:DEPTH_LOG2+2]};

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        ovf_d        = ovf_q;
        start        = 1'b0;
        act_idx_d    = act_idx_q;
        act_wdata_d  = act_wdata_q;
        act_wstrb_d  = act_wstrb_q;
        act_err_d    = act_err_q;
        pend_vld_d   = pend_vld_q;
        pend_idx_d   = pend_idx_q;
        pend_wdata_d = pend_wdata_q;
        pend_wstrb_d = pend_wstrb_q;
        pend_err_d   = pend_err_q;

        case (state_q)
            S_IDLE: begin
                if (mem_valid) begin
                    act_idx_d   = in_idx;
                    act_wdata_d = mem_wdata;
                    act_wstrb_d = mem_wstrb;
                    act_err_d   = in_err;
                    start       = 1'b1;
                end
            end
            S_WAIT: begin
                if (cnt_q == 4'd0) state_d = S_RESP;
                else               cnt_d   = cnt_q - 4'd1;
                if (mem_valid) begin
                    if (pend_vld_q) begin
                        ovf_d = 1'b1;
                    end else begin
                        pend_vld_d   = 1'b1;
                        pend_idx_d   = in_idx;
                        pend_wdata_d = mem_wdata;
                        pend_wstrb_d = mem_wstrb;
                        pend_err_d   = in_err;
                    end
                end
            end
            S_RESP: begin
                if (pend_vld_q) begin
                    // Promote pending; a same-cycle arrival refills the buffer.
                    act_idx_d   = pend_idx_q;
                    act_wdata_d = pend_wdata_q;
                    act_wstrb_d = pend_wstrb_q;
                    act_err_d   = pend_err_q;
                    start       = 1'b1;
                    if (mem_valid) begin
                        pend_idx_d   = in_idx;
                        pend_wdata_d = mem_wdata;
                        pend_wstrb_d = mem_wstrb;
                        pend_err_d   = in_err;
                    end else begin
                        pend_vld_d = 1'b0;
                    end
                end else if (mem_valid) begin
                    act_idx_d   = in_idx;
                    act_wdata_d = mem_wdata;
                    act_wstrb_d = mem_wstrb;
                    act_err_d   = in_err;
                    start       = 1'b1;
                end else begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase

        if (start) begin
            if (WAIT_CYCLES == 0) begin
                state_d = S_RESP;
            end else begin
                state_d = S_WAIT;
                cnt_d   = CNT_INIT;
            end
        end
    end

    // The array access happens on the edge that enters RESP, using the
    // request that will be active in RESP. For WAIT_CYCLES=0 this is the
    // request being captured on that same edge. Keeping the array in the
    // reset block stops any write from being committed while rst is low.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= S_IDLE;
            cnt_q        <= 4'd0;
            ovf_q        <= 1'b0;
            rdata_q      <= 32'd0;
            error_q      <= 1'b0;
            act_idx_q    <= '0;
            act_wdata_q  <= 32'd0;
            act_wstrb_q  <= 4'd0;
            act_err_q    <= 1'b0;
            pend_vld_q   <= 1'b0;
            pend_idx_q   <= '0;
            pend_wdata_q <= 32'd0;
            pend_wstrb_q <= 4'd0;
            pend_err_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            ovf_q        <= ovf_d;
            act_idx_q    <= act_idx_d;
            act_wdata_q  <= act_wdata_d;
            act_wstrb_q  <= act_wstrb_d;
            act_err_q    <= act_err_d;
            pend_vld_q   <= pend_vld_d;
            pend_idx_q   <= pend_idx_d;
            pend_wdata_q <= pend_wdata_d;
            pend_wstrb_q <= pend_wstrb_d;
            pend_err_q   <= pend_err_d;
            if (state_d == S_RESP) begin
                if (act_err_d) begin
                    rdata_q <= 32'd0;
                    error_q <= 1'b1;
                end else if (act_wstrb_d != 4'd0) begin
                    rdata_q <= 32'd0;
                    error_q <= 1'b0;
                    for (int i = 0; i < 4; i++) begin
                        if (act_wstrb_d[i]) mem[act_idx_d][8*i +: 8] <= act_wdata_d[8*i +: 8];
                    end
                end else begin
                    rdata_q <= mem[act_idx_d];
                    error_q <= 1'b0;
                end
            end else begin
                rdata_q <= 32'd0;
                error_q <= 1'b0;
            end
        end
    end

    assign mem_ready = (state_q == S_RESP);
    assign mem_rdata = rdata_q;
    assign mem_error = error_q;
    assign overflow  = ovf_q;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_dmem_responder.sv
// -----------------------------------------------------------------------------
// tb_dmem_responder
//
// Three responders (WAIT_CYCLES = 1, 2, 0) share one clock and one request
// stream. A transaction-level reference model is kept for each instance.
//
// Each accepted request is scheduled to respond at edge
// max(capture + W, previous_response + W + 1). A request is dropped when two
// accepted requests are still waiting to respond. Stores and loads take
// effect on a word array in response order. A reset discards everything
// that has not yet responded.
// -----------------------------------------------------------------------------
module tb_dmem_responder;

    localparam int N = 3;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
        int          resp;
    } req_t;

    logic        clk;
    logic        rst;
    logic        mem_valid;
    logic        mem_instr;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wstrb;
    logic        rdy  [N];
    logic [31:0] rdat [N];
    logic        err  [N];
    logic        ovf  [N];
    logic [1:0]  dst  [N];

    req_t        rq [N][$];
    logic [31:0] mm [N][4096];
    int          last_resp [N];
    logic        ovf_m [N];

    int cyc;
    int checks;
    int errors;

    dmem_responder #(.DEPTH_LOG2(12), .WAIT_CYCLES(1)) dut_w1 (
        .rst(rst), .clk(clk), .mem_valid(mem_valid), .mem_instr(mem_instr),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb),
        .mem_ready(rdy[0]), .mem_rdata(rdat[0]), .mem_error(err[0]),
        .overflow(ovf[0]), .dbg_state(dst[0])
    );

    dmem_responder #(.DEPTH_LOG2(12), .WAIT_CYCLES(2)) dut_w2 (
        .rst(rst), .clk(clk), .mem_valid(mem_valid), .mem_instr(mem_instr),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb),
        .mem_ready(rdy[1]), .mem_rdata(rdat[1]), .mem_error(err[1]),
        .overflow(ovf[1]), .dbg_state(dst[1])
    );

    dmem_responder #(.DEPTH_LOG2(12), .WAIT_CYCLES(0)) dut_w0 (
        .rst(rst), .clk(clk), .mem_valid(mem_valid), .mem_instr(mem_instr),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb),
        .mem_ready(rdy[2]), .mem_rdata(rdat[2]), .mem_error(err[2]),
        .overflow(ovf[2]), .dbg_state(dst[2])
    );

    // ---------------- clock ----------------
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // ---------------- model helpers ----------------
    function automatic int wait_of(int u);
        case (u)
            0:       return 1;
            1:       return 2;
            default: return 0;
        endcase
    endfunction

    function automatic logic range_err(logic [31:0] a);
`ifdef DMEM_RANGE_CHECK_EN
        return |a[31:14];
`else
        return (a == 32'hFFFF_FFFF) && (a != 32'hFFFF_FFFF);
`endif
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h (edge %0d)", tag, got, exp, cyc);
        end
    endtask

    // Compare every instance's outputs against its model after edge cyc.
    task automatic observe();
        for (int u = 0; u < N; u++) begin
            if (rq[u].size() > 0 && rq[u][0].resp == cyc) begin
                req_t        t;
                logic [11:0] idx;
                logic [31:0] exp_d;
                logic        exp_e;
                t     = rq[u].pop_front();
                idx   = t.addr[13:2];
                exp_e = range_err(t.addr);
                exp_d = 32'd0;
                if (!exp_e) begin
                    if (t.wstrb == 4'd0) begin
                        exp_d = mm[u][idx];
                    end else begin
                        for (int b = 0; b < 4; b++)
                            if (t.wstrb[b]) mm[u][idx][8*b +: 8] = t.wdata[8*b +: 8];
                    end
                end
                check($sformatf("u%0d ready", u), {31'd0, rdy[u]}, 32'd1);
                check($sformatf("u%0d rdata", u), rdat[u], exp_d);
                check($sformatf("u%0d error", u), {31'd0, err[u]}, {31'd0, exp_e});
            end else begin
                check($sformatf("u%0d idle_ready", u), {31'd0, rdy[u]}, 32'd0);
                check($sformatf("u%0d idle_rdata", u), rdat[u], 32'd0);
                check($sformatf("u%0d idle_error", u), {31'd0, err[u]}, 32'd0);
            end
            check($sformatf("u%0d overflow", u), {31'd0, ovf[u]}, {31'd0, ovf_m[u]});
        end
    endtask

    // ---------------- driver ----------------
    // Called just after a falling edge; the request is captured at edge cyc+1.
    task automatic step(input logic v, input logic [31:0] a, input logic [31:0] d,
                        input logic [3:0] s);
        mem_valid = v;
        mem_addr  = a;
        mem_wdata = d;
        mem_wstrb = s;
        mem_instr = 1'($urandom_range(0, 1));
        if (v && rst) begin
            for (int u = 0; u < N; u++) begin
                if (rq[u].size() >= 2) begin
                    ovf_m[u] = 1'b1;
                end else begin
                    req_t t;
                    int   w;
                    w       = wait_of(u);
                    t.addr  = a;
                    t.wdata = d;
                    t.wstrb = s;
                    t.resp  = (cyc + 1 + w > last_resp[u] + w + 1) ? cyc + 1 + w
                                                                   : last_resp[u] + w + 1;
                    last_resp[u] = t.resp;
                    rq[u].push_back(t);
                end
            end
        end
        @(posedge clk);
        cyc++;
        @(negedge clk);
        observe();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 32'd0, 32'd0, 4'd0);
    endtask

    task automatic do_reset();
        mem_valid = 1'b0;
        rst       = 1'b0;
        #1;
        for (int u = 0; u < N; u++) begin
            check($sformatf("u%0d rst_ready", u), {31'd0, rdy[u]}, 32'd0);
            check($sformatf("u%0d rst_rdata", u), rdat[u], 32'd0);
            check($sformatf("u%0d rst_error", u), {31'd0, err[u]}, 32'd0);
            check($sformatf("u%0d rst_overflow", u), {31'd0, ovf[u]}, 32'd0);
            rq[u].delete();
            last_resp[u] = -1000;
            ovf_m[u]     = 1'b0;
        end
        idle(2);
        rst = 1'b1;
        idle(1);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        checks    = 0;
        errors    = 0;
        cyc       = 0;
        rst       = 1'b0;
        mem_valid = 1'b0;
        mem_instr = 1'b0;
        mem_addr  = 32'd0;
        mem_wdata = 32'd0;
        mem_wstrb = 4'd0;
        for (int u = 0; u < N; u++) begin
            last_resp[u] = -1000;
            ovf_m[u]     = 1'b0;
        end
        @(negedge clk);
        do_reset();

        // Prime words 0..7 so every later load has a defined value.
        for (int w = 0; w < 8; w++) begin
            step(1'b1, 32'(w * 4), $urandom, 4'hF);
            idle(3);
        end

        // Full store, read back, byte-lane merge, read back.
        step(1'b1, 32'h10, 32'hDEADBEEF, 4'hF); idle(3);
        step(1'b1, 32'h10, 32'h0, 4'h0);        idle(3);
        step(1'b1, 32'h10, 32'h00AA0000, 4'h4); idle(3);
        step(1'b1, 32'h10, 32'h0, 4'h0);        idle(3);

        // Three back-to-back loads: the third is dropped at W=2.
        step(1'b1, 32'h0, 32'h0, 4'h0);
        step(1'b1, 32'h4, 32'h0, 4'h0);
        step(1'b1, 32'h8, 32'h0, 4'h0);
        idle(8);

        // Arrival in the RESP cycle while pending is full is not dropped.
        step(1'b1, 32'h0, 32'h0, 4'h0);
        step(1'b1, 32'h4, 32'h0, 4'h0);
        idle(1);
        step(1'b1, 32'h8, 32'h0, 4'h0);
        idle(10);

        // Alternating store/load to one word every cycle.
        for (int i = 0; i < 6; i++) begin
            step(1'b1, 32'h18, $urandom, 4'hF);
            step(1'b1, 32'h18, 32'h0, 4'h0);
        end
        idle(8);

        // Out-of-range store: faults with the range check, aliases word 0 without it.
        step(1'b1, 32'h0000_4000, 32'h1234_5678, 4'hF); idle(3);
        step(1'b1, 32'h0, 32'h0, 4'h0);                 idle(3);

        // Reset while W=2 is waiting with pending full; the aborted store must not land.
        step(1'b1, 32'h8, 32'hA5A5_0001, 4'hF);
        step(1'b1, 32'h8, 32'hA5A5_0002, 4'hF);
        do_reset();
        idle(6);
        step(1'b1, 32'h8, 32'h0, 4'h0);
        idle(4);

        // Randomized traffic over the primed words, occasionally with upper address bits.
        for (int i = 0; i < 400; i++) begin
            logic [31:0] a;
            logic [3:0]  s;
            a = 32'($urandom_range(0, 7) * 4) | 32'($urandom_range(0, 3));
            if ($urandom_range(0, 7) == 0) a = a | (32'($urandom_range(1, 15)) << 14);
            s = ($urandom_range(0, 1) == 1) ? 4'($urandom_range(1, 15)) : 4'd0;
            if ($urandom_range(0, 2) != 0) step(1'b1, a, $urandom, s);
            else                           idle(1);
        end
        idle(12);

        for (int u = 0; u < N; u++)
            check($sformatf("u%0d drained", u), 32'(rq[u].size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
